piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 138 +++++++++++++
 tb/tb_piso_serializer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in/serial-out serializer. A WIDTH-bit word is captured on an
//   edge where load=1 and ready=1. It is then shifted out one bit per clock,
//   with ser_valid qualifying each bit. A one-cycle done pulse follows the
//   last bit, and after that the block returns to idle.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   reset_n    synchronous active-low reset
//   load       request to accept d_in (honoured only while ready=1)
//   d_in       parallel word, sampled on the accepting edge
//   ready      1 = idle, a load will be accepted
//   ser_out    current serial bit, forced to 0 when ser_valid=0
//   ser_valid  1 = ser_out carries a data bit this cycle
//   done       one-cycle pulse in the cycle after the last bit
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1 = bit WIDTH-1 leaves first, 0 = bit 0 leaves first

module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count_reg;
    logic             ready_reg;
    logic             valid_reg;
    logic             done_reg;

    logic [WIDTH-1:0] shift_next;
    logic             head;

    // The shift register moves one place toward its head every SHIFT cycle.
    // The tail end is zero-filled, so the register is empty once the word
    // has left.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_fill
                    assign shift_next[gi] = 1'b0;
                end else begin : g_move
                    assign shift_next[gi] = shift_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_fill
                    assign shift_next[gi] = 1'b0;
                end else begin : g_move
                    assign shift_next[gi] = shift_reg[gi+1];
                end
            end
        end

        if (MSB_FIRST) begin : g_head_msb
            assign head = shift_reg[WIDTH-1];
        end else begin : g_head_lsb
            assign head = shift_reg[0];
        end
    endgenerate

    // One FSM block. The status flags are registered alongside the state,
    // so no input reaches an output combinationally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        shift_reg <= d_in;
                        count_reg <= '0;
                        state_reg <= SHIFT;
                        ready_reg <= 1'b0;
                        valid_reg <= 1'b1;
                    end
                end

                SHIFT: begin
                    shift_reg <= shift_next;
                    // The counter stops at the last bit index rather than wrapping.
                    if (count_reg == LAST_BIT) begin
                        state_reg <= DONE;
                        valid_reg <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end

                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_reg;
    assign ser_valid = valid_reg;
    assign done      = done_reg;
    // Gated so that the line idles at 0 outside the data cycles.
    assign ser_out   = valid_reg & head;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer. Two instances share the same stimulus:
// one shifts MSB first and the other shifts LSB first. A reference model
// tracks how long the block stays busy after each accepted word. For every
// accepted word it queues the per-cycle output tuple {ready, ser_valid,
// ser_out, done} that each instance must show. A monitor on the falling
// edge pops these tuples and compares them against the DUT outputs.

module tb_piso_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load;
    logic [W-1:0] d_in;

    logic ready_m, ser_out_m, ser_valid_m, done_m;
    logic ready_l, ser_out_l, ser_valid_l, done_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .d_in      (d_in),
        .ready     (ready_m),
        .ser_out   (ser_out_m),
        .ser_valid (ser_valid_m),
        .done      (done_m)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .d_in      (d_in),
        .ready     (ready_l),
        .ser_out   (ser_out_l),
        .ser_valid (ser_valid_l),
        .done      (done_l)
    );

    // Tuple layout: {ready, ser_valid, ser_out, done}
    localparam logic [3:0] IDLE_TUPLE = 4'b1000;

    logic [3:0] act [2];
    assign act[0] = {ready_m, ser_valid_m, ser_out_m, done_m};
    assign act[1] = {ready_l, ser_valid_l, ser_out_l, done_l};

    logic [3:0] exp_q [2][$];

    // ---------------- reference model ----------------
    // The block is busy for W+1 cycles after an accepting edge: W bit cycles
    // followed by one done cycle. Reset discards everything still pending.
    int busy = 0;
    always @(posedge clk) begin
        if (reset_n !== 1'b1) begin
            busy = 0;
            exp_q[0].delete();
            exp_q[1].delete();
        end else if (busy == 0) begin
            if (load === 1'b1) begin
                for (int i = 0; i < W; i++) begin
                    exp_q[0].push_back({1'b0, 1'b1, d_in[W-1-i], 1'b0});
                    exp_q[1].push_back({1'b0, 1'b1, d_in[i], 1'b0});
                end
                exp_q[0].push_back(4'b0001);
                exp_q[1].push_back(4'b0001);
                busy = W + 1;
            end
        end else begin
            busy = busy - 1;
        end
    end

    // ---------------- monitor ----------------
    bit mon_en = 1'b0;
    int cycle = 0;
    int fall_prev = -1;
    int fall_last = -1;
    logic ready_prev = 1'b1;

    task automatic check_tuple(input string name, input int cyc,
                               input logic [3:0] a, input logic [3:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got {rdy,vld,out,done}=%b expected %b",
                     name, cyc, a, e);
        end
    endtask

    always @(negedge clk) begin
        cycle++;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [3:0] e;
                if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
                else                     e = IDLE_TUPLE;
                check_tuple(i == 0 ? "msb_first" : "lsb_first", cycle, act[i], e);
            end
            if (ready_prev === 1'b1 && ready_m === 1'b0) begin
                fall_prev = fall_last;
                fall_last = cycle;
            end
            ready_prev = ready_m;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic ld, input logic [W-1:0] d, input logic rn);
        load    = ld;
        d_in    = d;
        reset_n = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, W'($urandom), 1'b1);
    endtask

    initial begin
        load    = 1'b1;
        d_in    = 8'hFF;
        reset_n = 1'b0;

        // Reset held for two edges while load=1 and d_in=FF.
        cyc(1'b1, 8'hFF, 1'b0);
        mon_en = 1'b1;
        cyc(1'b1, 8'hFF, 1'b0);
        idle(2);

        // A5 and 1E, each shifted in both bit orders.
        cyc(1'b1, 8'hA5, 1'b1);
        idle(11);
        cyc(1'b1, 8'h1E, 1'b1);
        idle(11);

        // Load pulses during bit 3 and during the done cycle are ignored.
        cyc(1'b1, 8'hF0, 1'b1);
        idle(3);
        cyc(1'b1, 8'h0F, 1'b1);
        idle(4);
        cyc(1'b1, 8'h0F, 1'b1);
        idle(3);

        // Reset in the bit-4 cycle abandons the word without a done pulse.
        cyc(1'b1, 8'hFF, 1'b1);
        idle(4);
        cyc(1'b0, 8'h00, 1'b0);
        idle(1);
        cyc(1'b1, 8'h81, 1'b1);
        idle(11);

        // load held high: back-to-back words 55 then AA.
        cyc(1'b1, 8'h55, 1'b1);
        for (int k = 0; k < 10; k++) cyc(1'b1, 8'hAA, 1'b1);
        idle(11);
        checks++;
        if (fall_last - fall_prev != W + 2) begin
            errors++;
            $display("FAIL load_spacing: got %0d cycles expected %0d",
                     fall_last - fall_prev, W + 2);
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            cyc(logic'($urandom_range(0, 2) == 0), W'($urandom),
                logic'($urandom_range(0, 60) != 0));
        end
        idle(W + 4);

        checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending entries expected 0",
                     exp_q[0].size(), exp_q[1].size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
